// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-mode Nk/Nr,
// FSM state encoding and round-key word-storage sizing.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;
    localparam logic [1:0] KEY_LEN_BAD = 2'b11;

    localparam int WORDS_128  = 44;
    localparam int WORDS_192  = 52;
    localparam int WORDS_256  = 60;
    localparam int WORD_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd10;
        endcase
    endfunction

    function automatic int key_bits_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: key_bits_of = 128;
            KEY_LEN_192: key_bits_of = 192;
            default:     key_bits_of = 256;
        endcase
    endfunction

    function automatic int max_words(input int max_key_bits);
        if (max_key_bits >= 256)      max_words = WORDS_256;
        else if (max_key_bits >= 192) max_words = WORDS_192;
        else                          max_words = WORDS_128;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for a single byte.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/key_schedule_param.sv
// AES key expansion for 128/192/256-bit keys, one schedule word per cycle,
// with random access to any round key whose four words are already stored.
module key_schedule_param
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS  = 256,
    parameter bit RD_REGISTERED = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         keys_valid,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    localparam int NUM_WORDS = max_words(MAX_KEY_BITS);
    typedef logic [WORD_IDX_W-1:0] widx_t;

    ks_state_e   state_q, state_d;
    widx_t       idx_q, idx_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [1:0]  len_q, len_d;
    logic        done_q, done_d, err_q, err_d, kv_q, kv_d;
    logic [3:0]  nr_out_q, nr_out_d;
    logic [31:0] w_q [NUM_WORDS];

    logic         accept, legal, load, write_word, rd_ok;
    logic [3:0]   nk_cur, nr_cur, nk_new;
    widx_t        last_idx, prev_addr, back_addr, rd_addr;
    logic [31:0]  prev_word, back_word, sub_in, sub_out, temp, new_word;
    logic [127:0] rd_key_d;

    assign nk_cur     = nk_of(len_q);
    assign nr_cur     = nr_of(len_q);
    assign nk_new     = nk_of(key_len);
    assign last_idx   = {nr_cur, 2'b00} + widx_t'(3);
    assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy       = (state_q == ST_EXPAND);
    assign accept     = in_valid && in_ready;
    assign legal      = (key_len != KEY_LEN_BAD) && (key_bits_of(key_len) <= MAX_KEY_BITS);
    assign done       = done_q;
    assign err        = err_q;
    assign keys_valid = kv_q;
    assign num_rounds = nr_out_q;

    // Operand addresses are parked at 0 outside EXPAND so they never leave the array.
    always_comb begin
        prev_addr = '0;
        back_addr = '0;
        if (state_q == ST_EXPAND) begin
            prev_addr = idx_q - widx_t'(1);
            back_addr = idx_q - widx_t'(nk_cur);
        end
    end

    assign prev_word = w_q[prev_addr];
    assign back_word = w_q[back_addr];

    always_comb begin
        sub_in = prev_word;
        if (phase_q == 3'd0) sub_in = {prev_word[23:0], prev_word[31:24]};
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (phase_q == 3'd0)                         temp = sub_out ^ {rcon_q, 24'h0};
        else if (nk_cur == 4'd8 && phase_q == 3'd4)  temp = sub_out;
    end

    assign new_word = back_word ^ temp;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        rcon_d     = rcon_q;
        len_d      = len_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        kv_d       = kv_q;
        nr_out_d   = nr_out_q;
        load       = 1'b0;
        write_word = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    kv_d     = 1'b0;
                    nr_out_d = 4'd0;
                    if (legal) begin
                        load    = 1'b1;
                        len_d   = key_len;
                        idx_d   = widx_t'(nk_new);
                        phase_d = 3'd0;
                        rcon_d  = 8'h01;
                        state_d = ST_EXPAND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                write_word = 1'b1;
                idx_d      = idx_q + widx_t'(1);
                phase_d    = ({1'b0, phase_q} == nk_cur - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
                if (idx_q == last_idx) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    kv_d     = 1'b1;
                    nr_out_d = nr_cur;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            phase_q  <= 3'd0;
            rcon_q   <= 8'h01;
            len_q    <= KEY_LEN_128;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            kv_q     <= 1'b0;
            nr_out_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            rcon_q   <= rcon_d;
            len_q    <= len_d;
            done_q   <= done_d;
            err_q    <= err_d;
            kv_q     <= kv_d;
            nr_out_q <= nr_out_d;
        end
    end

    // Word storage is never reset; the read gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_new) w_q[widx_t'(k)] <= key[255 - 32*k -: 32];
            end
        end
        if (write_word) w_q[idx_q] <= new_word;
    end

    always_comb begin
        rd_ok    = (rd_round <= nr_cur) &&
                   ({1'b0, idx_q} >= ({1'b0, rd_round, 2'b00} + 7'd4));
        rd_addr  = rd_ok ? {rd_round, 2'b00} : '0;
        rd_key_d = '0;
        if (rd_ok) begin
            rd_key_d = {w_q[rd_addr], w_q[rd_addr + widx_t'(1)],
                        w_q[rd_addr + widx_t'(2)], w_q[rd_addr + widx_t'(3)]};
        end
    end

    if (RD_REGISTERED) begin : g_rd_reg
        logic [127:0] rd_key_q;
        always_ff @(posedge clk) begin
            if (reset) rd_key_q <= '0;
            else       rd_key_q <= rd_key_d;
        end
        assign rd_key = rd_key_q;
    end else begin : g_rd_comb
        assign rd_key = rd_key_d;
    end

endmodule

// File: tb/tb_key_schedule_param.sv
// Bench for key_schedule_param: a FIPS-197 reference model checked every cycle,
// plus directed known-answer vectors and a second instance limited to 128-bit keys.
module tb_key_schedule_param;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         in_valid = 1'b0, in_valid_b = 1'b0;
    logic [1:0]   key_len = 2'b00, key_len_b = 2'b00;
    logic [255:0] key = '0;
    logic [3:0]   rd_round = 4'd0, rd_round_b = 4'd0;
    logic         in_ready, busy, done, err, keys_valid;
    logic         in_ready_b, busy_b, done_b, err_b, keys_valid_b;
    logic [3:0]   num_rounds, num_rounds_b;
    logic [127:0] rd_key, rd_key_b;

    key_schedule_param dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .key_len(key_len), .key(key), .busy(busy), .done(done), .err(err),
        .keys_valid(keys_valid), .num_rounds(num_rounds),
        .rd_round(rd_round), .rd_key(rd_key)
    );

    key_schedule_param #(.MAX_KEY_BITS(128), .RD_REGISTERED(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .key_len(key_len_b), .key(key), .busy(busy_b), .done(done_b), .err(err_b),
        .keys_valid(keys_valid_b), .num_rounds(num_rounds_b),
        .rd_round(rd_round_b), .rd_key(rd_key_b)
    );

    int n_vec = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;
    int busy_run = 0;
    int done_cnt = 0;
    bit seen;
    int cnt_b;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_tb [256];
    logic [31:0] calc_w  [60];
    logic [31:0] mw      [60];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] rcon_of(input int j);
        case (j)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1b;  default: return 8'h36;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_tb[x[31:24]], sbox_tb[x[23:16]], sbox_tb[x[15:8]], sbox_tb[x[7:0]]};
    endfunction

    task automatic model_calc(input logic [255:0] k, input int nk);
        int total;
        logic [31:0] t;
        total = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) calc_w[i] = 32'h0;
        for (int i = 0; i < nk; i++) calc_w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = calc_w[i-1];
            if (i % nk == 0)                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_word(t);
            calc_w[i] = calc_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] calc_round(input int r);
        return {calc_w[4*r], calc_w[4*r+1], calc_w[4*r+2], calc_w[4*r+3]};
    endfunction

    // Cycle-level expectation: how many schedule words exist, and what the outputs must show.
    bit          m_active, m_done, m_err, m_kv;
    int          m_cnt, m_total, m_len_nr;
    logic [3:0]  m_nrout;
    logic [127:0] m_rd;

    function automatic logic [127:0] model_round(input int r);
        if (r <= m_len_nr && m_cnt >= 4*r + 4)
            return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
        return '0;
    endfunction

    always @(posedge clk) begin
        int nk;
        if (reset) begin
            m_active = 0; m_done = 0; m_err = 0; m_kv = 0;
            m_cnt = 0; m_len_nr = 10; m_nrout = 4'd0; m_rd = '0;
        end else begin
            m_rd   = model_round(int'(rd_round));
            m_done = 0;
            m_err  = 0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == m_total) begin
                    m_active = 0; m_done = 1; m_kv = 1; m_nrout = 4'(m_len_nr);
                end
            end else if (in_valid) begin
                m_kv = 0;
                m_nrout = 4'd0;
                if (key_len == 2'b11) begin
                    m_err = 1;
                end else begin
                    nk = (key_len == 2'b00) ? 4 : (key_len == 2'b01) ? 6 : 8;
                    model_calc(key, nk);
                    for (int i = 0; i < 60; i++) mw[i] = calc_w[i];
                    m_len_nr = nk + 6;
                    m_total  = 4 * (m_len_nr + 1);
                    m_cnt    = nk;
                    m_active = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_output("in_ready",   in_ready,   !m_active);
            check_output("busy",       busy,       m_active);
            check_output("done",       done,       m_done);
            check_output("err",        err,        m_err);
            check_output("keys_valid", keys_valid, m_kv);
            check_output("num_rounds", num_rounds, m_nrout);
            check_output("rd_key",     rd_key,     m_rd);
        end
    end

    always @(negedge clk) begin
        if (busy) busy_run++;
        if (done) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [1:0] len, input logic [255:0] k);
        key_len  = len;
        key      = k;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        build_sbox();
        model_calc(K128, 4);
        check_output("model_128_r1",  calc_round(1),  R128_1);
        check_output("model_128_r10", calc_round(10), R128_10);
        model_calc(K192, 6);
        check_output("model_192_r12", calc_round(12), R192_12);
        model_calc(K256, 8);
        check_output("model_256_r14", calc_round(14), R256_14);

        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_output("rst_in_ready",   in_ready,   1'b1);
        check_output("rst_busy",       busy,       1'b0);
        check_output("rst_keys_valid", keys_valid, 1'b0);
        check_output("rst_num_rounds", num_rounds, 4'd0);
        check_output("rst_rd_key",     rd_key,     '0);
        step();

        // AES-128, round 1 observed while the schedule is still being built
        rd_round = 4'd1; busy_run = 0; done_cnt = 0;
        apply_stimulus(2'b00, K128);
        @(negedge clk);
        check_output("aes128_rd1_early", rd_key, '0);
        step(); step();
        key_len = 2'b11; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check_output("aes128_rd1_late", rd_key, R128_1);
        wait_done(100, seen);
        check_output("aes128_done_seen",   seen,     1'b1);
        check_output("aes128_busy_cycles", busy_run, 40);
        check_output("aes128_done_pulses", done_cnt, 1);
        rd_round = 4'd10;
        step();
        @(negedge clk);
        check_output("aes128_r10", rd_key, R128_10);
        rd_round = 4'd11;
        step();
        @(negedge clk);
        check_output("aes128_r11_zero", rd_key, '0);
        step();

        // AES-192 accepted straight out of DONE
        rd_round = 4'd12; busy_run = 0;
        apply_stimulus(2'b01, K192);
        wait_done(120, seen);
        @(negedge clk);
        check_output("aes192_done_seen",   seen,       1'b1);
        check_output("aes192_num_rounds",  num_rounds, 4'd12);
        check_output("aes192_r12",         rd_key,     R192_12);
        check_output("aes192_busy_cycles", busy_run,   46);
        step();

        // AES-256
        rd_round = 4'd14; busy_run = 0;
        apply_stimulus(2'b10, K256);
        wait_done(120, seen);
        @(negedge clk);
        check_output("aes256_done_seen",   seen,       1'b1);
        check_output("aes256_num_rounds",  num_rounds, 4'd14);
        check_output("aes256_r14",         rd_key,     R256_14);
        check_output("aes256_busy_cycles", busy_run,   52);
        step();

        // Illegal key length is rejected with an err pulse
        rd_round = 4'd0;
        apply_stimulus(2'b11, K256);
        @(negedge clk);
        check_output("bad_len_err",        err,        1'b1);
        check_output("bad_len_busy",       busy,       1'b0);
        check_output("bad_len_keys_valid", keys_valid, 1'b0);
        step();
        @(negedge clk);
        check_output("bad_len_err_cleared", err, 1'b0);
        step();

        // Reset part-way through an expansion, then a clean AES-128 run
        done_cnt = 0;
        apply_stimulus(2'b00, K128);
        repeat (19) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_output("abort_in_ready",   in_ready,   1'b1);
        check_output("abort_keys_valid", keys_valid, 1'b0);
        check_output("abort_busy",       busy,       1'b0);
        repeat (40) step();
        check_output("abort_no_done", done_cnt, 0);
        apply_stimulus(2'b00, K128);
        wait_done(100, seen);
        check_output("rerun_done_seen", seen, 1'b1);
        rd_round = 4'd10;
        step();
        @(negedge clk);
        check_output("rerun_r10", rd_key, R128_10);
        step();

        // 128-bit-only instance with combinational read port
        key = K256; key_len_b = 2'b10; in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        @(negedge clk);
        check_output("b_256_err",  err_b,  1'b1);
        check_output("b_256_busy", busy_b, 1'b0);
        step();
        key = K128; key_len_b = 2'b00; in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        seen = 0; cnt_b = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (busy_b) cnt_b++;
            if (done_b) seen = 1;
        end
        check_output("b_done_seen",   seen,         1'b1);
        check_output("b_busy_cycles", cnt_b,        40);
        check_output("b_num_rounds",  num_rounds_b, 4'd10);
        rd_round_b = 4'd10;
        #1;
        check_output("b_r10", rd_key_b, R128_10);
        rd_round_b = 4'd11;
        #1;
        check_output("b_r11_zero", rd_key_b, '0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
